// File: rtl/serial_frame_rx.sv
// Serial deframer: start-bit detect, LSB-first data assembly, optional even parity and stop check,
// with good words queued in a small valid/ready FIFO.
module serial_frame_rx #(
    parameter int unsigned NBITS_DATA = 4,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk_2,
    input  logic                          reset,
    input  logic                          serial_in,
    input  logic                          sample_en,
    input  logic                          rx_ready,
    output logic [NBITS_DATA-1:0]         rx_data,
    output logic                          rx_valid,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned CntW   = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
    localparam logic [CntW-1:0]   LastBit  = CntW'(NBITS_DATA - 1);
    localparam logic [CountW-1:0] FullCnt  = CountW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StBreak} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NBITS_DATA-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  push;
    logic                  parity_ok;

    logic [NBITS_DATA-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CountW-1:0]     count_q, count_d;
    logic [NBITS_DATA-1:0] data_q, data_d;
    logic                  ovr_q, ovr_d;
    logic                  pop, full, wr_en;

    assign parity_ok = (PARITY_EN == 0) || !(^{shift_q, par_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        push    = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!serial_in) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
                StData: begin
                    shift_d[cnt_q] = serial_in;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    par_d   = serial_in;
                    state_d = StStop;
                end
                StStop: begin
                    // A bad stop bit masks any parity problem: only one error pulse per frame.
                    if (!serial_in) begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end else if (!parity_ok) begin
                        perr_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBreak: begin
                    if (serial_in) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pop      = (count_q != '0) && rx_ready;
        full     = (count_q == FullCnt);
        wr_en    = push && (!full || pop);
        ovr_d    = ovr_q | (push && full && !pop);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
        count_d  = count_q;
        if (wr_en && !pop) count_d = count_q + 1'b1;
        if (!wr_en && pop) count_d = count_q - 1'b1;
        // Head register holds its last value once the FIFO drains.
        data_d = data_q;
        if (count_d != '0) begin
            data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            ovr_q    <= ovr_d;
            if (wr_en) mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = (count_q != '0);
    assign busy       = (state_q != StIdle);
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed scenarios plus random frames checked against a queue model.
module tb_serial_frame_rx;

    localparam int unsigned NB    = 4;
    localparam int unsigned PEN   = 1;
    localparam int unsigned DEPTH = 2;

    logic                       clk_2;
    logic                       reset;
    logic                       serial_in;
    logic                       sample_en;
    logic                       rx_ready;
    logic [NB-1:0]              rx_data;
    logic                       rx_valid;
    logic                       busy;
    logic                       parity_err;
    logic                       frame_err;
    logic                       overrun;
    logic [$clog2(DEPTH):0]     fifo_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: words the design should currently hold, plus sticky overrun.
    logic [NB-1:0] exp_q[$];
    logic          exp_ovr;

    logic [NB-1:0] rd;
    logic          rbad, rstop, rrdy;

    serial_frame_rx #(
        .NBITS_DATA (NB),
        .PARITY_EN  (PEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .serial_in  (serial_in),
        .sample_en  (sample_en),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() > 0));
        check({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        if (exp_q.size() > 0) check({tag, "_data"}, 32'(rx_data), 32'(exp_q[0]));
    endtask

    // One bit period: three unstrobed clocks with junk on the line, then the strobed sample.
    task automatic send_bit(input logic b, input logic rdy);
        sample_en = 1'b0;
        repeat (3) begin
            serial_in = 1'($urandom);
            tick();
        end
        serial_in = b;
        sample_en = 1'b1;
        rx_ready  = rdy;
        tick();
        sample_en = 1'b0;
        rx_ready  = 1'b0;
    endtask

    task automatic send_frame(input logic [NB-1:0] d, input logic bad_par, input logic stop,
                              input logic rdy_on_stop);
        logic exp_perr, exp_ferr;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < NB; i++) send_bit(d[i], 1'b0);
        send_bit((^d) ^ bad_par, 1'b0);
        send_bit(stop, rdy_on_stop);
        exp_ferr = !stop;
        exp_perr = stop && bad_par;
        if (stop && !bad_par) begin
            if (rdy_on_stop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovr = 1'b1;
        end
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("parity_err", 32'(parity_err), 32'(exp_perr));
        check("busy_after_stop", 32'(busy), 32'(!stop));
        check_fifo("after_stop");
        tick();
        check("frame_err_1cyc", 32'(frame_err), 0);
        check("parity_err_1cyc", 32'(parity_err), 0);
        if (!stop) begin
            send_bit(1'b1, 1'b0);
            check("break_exit", 32'(busy), 0);
        end
    endtask

    task automatic pop_one();
        if (exp_q.size() > 0) check("pop_head", 32'(rx_data), 32'(exp_q[0]));
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_fifo("after_pop");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        serial_in = 1'b1;
        sample_en = 1'b1;
        rx_ready  = 1'b0;
        exp_ovr   = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_perr", 32'(parity_err), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_data", 32'(rx_data), 0);
        check_fifo("rst");
        reset = 1'b1;
        repeat (5) begin
            tick();
            check("idle_busy", 32'(busy), 0);
            check("idle_count", 32'(fifo_count), 0);
        end

        // Line activity without strobes must not start a frame.
        sample_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serial_in = 1'(i);
            tick();
            check("gated_busy", 32'(busy), 0);
        end

        send_frame(4'hD, 1'b0, 1'b1, 1'b0);
        pop_one();
        send_frame(4'hD, 1'b1, 1'b1, 1'b0);
        send_frame(4'h6, 1'b0, 1'b0, 1'b0);

        // Stop bit low with the line held low: BREAK must persist until a high sample.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < NB; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("brk_ferr", 32'(frame_err), 1);
        check("brk_perr", 32'(parity_err), 0);
        send_bit(1'b0, 1'b0);
        check("brk_hold", 32'(busy), 1);
        send_bit(1'b1, 1'b0);
        check("brk_release", 32'(busy), 0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0);
        pop_one();

        // Overrun: third word dropped with no pop.
        send_frame(4'h1, 1'b0, 1'b1, 1'b0);
        send_frame(4'h2, 1'b0, 1'b1, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0);
        check("ovr_set", 32'(overrun), 1);
        pop_one();
        pop_one();
        pop_one();

        // Full FIFO with a pop on the push edge accepts the word.
        do_reset();
        send_frame(4'h1, 1'b0, 1'b1, 1'b0);
        send_frame(4'h2, 1'b0, 1'b1, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b1);
        check("full_pop_ovr", 32'(overrun), 0);
        pop_one();
        pop_one();

        // Reset mid-frame aborts the frame and clears the FIFO immediately.
        send_frame(4'h5, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("abort_busy_pre", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        exp_ovr = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check_fifo("abort");
        @(posedge clk_2);
        #1 reset = 1'b1;
        send_frame(4'hA, 1'b0, 1'b1, 1'b0);
        pop_one();

        for (int n = 0; n < 40; n++) begin
            rd    = NB'($urandom);
            rbad  = ($urandom_range(0, 4) == 0);
            rstop = ($urandom_range(0, 5) != 0);
            rrdy  = ($urandom_range(0, 3) == 0);
            send_frame(rd, rbad, rstop, rrdy);
            if ($urandom_range(0, 1) == 1) pop_one();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
